mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline register between the memory stage and the writeback stage of the SPARC pipeline.
- Each cycle it takes the memory-stage result: either the ALU result or the data-memory read word, chosen by the load flag.
- Loads are aligned and sign/zero-extended according to size. Misaligned halfword and word accesses are flagged.
- Results are held in a 2-entry skid buffer under a valid/ready handshake, so writeback back-pressure never drops an instruction.
- The head entry is also exported as a forwarding source for the execute stage.

Parameters:
- DW, 32, data width
- RW_BITS, 5, destination-register index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all buffered entries (trap or branch squash)
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept; high when the skid entry is empty
- alu_out  in  DW  ALU result / effective address
- mem_out  in  DW  data memory read word, right-justified for byte/half
- mem_load  in  1  1 = instruction is a load
- size  in  2  00 byte, 01 half, 10 word
- load_signed  in  1  1 = sign-extend (ldsb/ldsh)
- rd  in  RW_BITS  destination register
- rf_le  in  1  register-file write enable requested
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback consumes head this cycle
- wb_data  out  DW  formatted result
- wb_rd  out  RW_BITS  destination
- wb_le  out  1  write enable; forced 0 on a trapping entry
- trap_misaligned  out  1  head entry is a misaligned load
- fwd_valid  out  1  out_valid & wb_le
- fwd_rd  out  RW_BITS  equals wb_rd
- fwd_data  out  DW  equals wb_data

Behaviour:
- Format (combinational, on the input side), when mem_load=1:
  - size 00: byte = mem_out[7:0], extended by load_signed.
  - size 01: half = mem_out[15:0], extended by load_signed.
  - size 10: full mem_out.
  - size 11: data 0, treated as misaligned.
- When mem_load=0, data = alu_out unchanged.
- Misalignment is checked on loads only, using alu_out[1:0]:
  - half with bit0=1 is misaligned.
  - word with [1:0]!=0 is misaligned.
  - size 11 is always misaligned.
  - A misaligned entry stores le=0 and trap=1.
- Storage: head entry H and skid entry S, each holding {valid, data, rd, le, trap}.
- Acceptance and outputs:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready is registered and equals !S.valid.
  - out_valid = H.valid.
  - wb_* and trap_misaligned come from H only (registered). Latency is 1 cycle from accept to visible.
- Sequential update, one branch per clock, in priority order:
  1. reset or flush: H.valid=0, S.valid=0.
  2. Pop with S valid: H<=S. If accepting, S<=new, otherwise S.valid=0.
  3. Pop with S empty: if accepting, H<=new, otherwise H.valid=0.
  4. No pop, accepting, H valid: S<=new (in_ready falls the next cycle).
  5. No pop, accepting, H empty: H<=new.
- Stability: while H is valid and not popped, all wb_* outputs stay stable.
- Reset values: out_valid=0, wb_data=0, wb_rd=0, wb_le=0, trap_misaligned=0, fwd_valid=0, in_ready=1 in the cycle after reset.
- Data fields of invalid entries are cleared to 0, so outputs read 0 when out_valid=0.
- Boundary conditions:
  - Flush coincident with accept: the new entry is discarded.
  - Flush coincident with pop: the pop is harmless (all entries cleared).
  - Reset mid-stall drops both entries.
  - An accept in the same cycle as a pop from full (S valid) is legal and keeps the buffer full.
- Throughput: sustained 1 instruction/cycle with out_ready=1.
- rd=0 (%g0) is passed through; the register file discards it.

Decomposition:
- Shared package pipe_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - the entry struct mw_entry_t {valid, data, rd, le, trap}.
- Natural sub-module: load_formatter. It is the combinational extend-and-misalign logic: inputs mem_out, alu_out, mem_load, size, load_signed; outputs data, trap. It also lets the store path reuse the size-check logic.

Test Plan:
- Reset, then a load with mem_out=0x000000F0, size=00, signed=1, rd=3, le=1, out_ready=1 -> next cycle wb_data=0xFFFFFFF0, wb_rd=3, wb_le=1, fwd_valid=1.
- ALU op with alu_out=0x12345678, mem_load=0 -> wb_data=0x12345678. A half load with mem_out=0x00008001, signed=0 -> 0x00008001; with signed=1 -> 0xFFFF8001.
- Word load with alu_out=0x00000102 -> trap_misaligned=1, wb_le=0, fwd_valid=0. Half load at 0x...04 -> no trap.
- Hold out_ready=0 and offer 3 back-to-back entries A, B, C:
  - A sits in H, B in S, in_ready=0, C held off.
  - Raise out_ready: output sequence is A, B, C with no loss or duplication.
- With H and S full, assert flush for 1 cycle together with in_valid -> next cycle out_valid=0, in_ready=1, no write enable issued.
- Random valid/ready toggling for 1000 cycles against a scoreboard -> the in-order output stream matches the accepted stream exactly.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the memory/writeback pipeline boundary.
//   - Load size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 is unused and
//     is always treated as misaligned).
//   - mw_entry_t: one buffered instruction result {valid, data, rd, le, trap}.
//   - size_misaligned(): alignment check, shared by the load and store paths.
package pipe_pkg;

    localparam int MW_DW = 32;  // datapath width carried by mw_entry_t
    localparam int MW_RW = 5;   // register index width carried by mw_entry_t

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [MW_DW-1:0] data;
        logic [MW_RW-1:0] rd;
        logic             le;
        logic             trap;
    } mw_entry_t;

    // True when an access of the given size at an address whose two low
    // bits are addr_lo is not naturally aligned.
    function automatic logic size_misaligned(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational result formatter for the memory stage.
//   mem_out     : data memory read word, right-justified for byte/half
//   alu_out     : ALU result / effective address
//   mem_load    : 1 = load, select and format mem_out; 0 = pass alu_out
//   size        : SZ_BYTE / SZ_HALF / SZ_WORD
//   load_signed : sign-extend byte/half loads
//   data        : formatted result
//   trap        : load is misaligned
module load_formatter
    import pipe_pkg::*;
#(
    parameter int DW = MW_DW
) (
    input  logic [DW-1:0] mem_out,
    input  logic [DW-1:0] alu_out,
    input  logic          mem_load,
    input  logic [1:0]    size,
    input  logic          load_signed,
    output logic [DW-1:0] data,
    output logic          trap
);

    always_comb begin
        data = alu_out;
        trap = 1'b0;
        if (mem_load) begin
            trap = size_misaligned(size, alu_out[1:0]);
            case (size)
                SZ_BYTE: data = {{(DW-8){load_signed & mem_out[7]}}, mem_out[7:0]};
                SZ_HALF: data = {{(DW-16){load_signed & mem_out[15]}}, mem_out[15:0]};
                SZ_WORD: data = mem_out;
                default: data = '0;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with a 2-entry skid buffer.
//   clk, reset (sync, active-high), flush (sync kill of buffered entries)
//   in_valid/in_ready  : memory-stage handshake
//   alu_out, mem_out, mem_load, size, load_signed, rd, rf_le : instruction
//   out_valid/out_ready: writeback handshake
//   wb_data, wb_rd, wb_le, trap_misaligned : head entry (registered)
//   fwd_valid, fwd_rd, fwd_data            : head entry as forwarding source
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on registered state (skid entry empty),
// so it never combinationally depends on out_ready. The head entry holds
// stable until popped; a popped head is replaced by the skid entry if one
// is waiting, otherwise by the incoming instruction.
//
// DW and RW_BITS must match MW_DW / MW_RW in pipe_pkg, since mw_entry_t
// carries the stored fields.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int DW      = MW_DW,
    parameter int RW_BITS = MW_RW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      alu_out,
    input  logic [DW-1:0]      mem_out,
    input  logic               mem_load,
    input  logic [1:0]         size,
    input  logic               load_signed,
    input  logic [RW_BITS-1:0] rd,
    input  logic               rf_le,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      wb_data,
    output logic [RW_BITS-1:0] wb_rd,
    output logic               wb_le,
    output logic               trap_misaligned,
    output logic               fwd_valid,
    output logic [RW_BITS-1:0] fwd_rd,
    output logic [DW-1:0]      fwd_data
);

    mw_entry_t h_q;     // head: visible to writeback
    mw_entry_t s_q;     // skid: absorbs one accept while the head stalls
    mw_entry_t new_e;

    logic [DW-1:0] fmt_data;
    logic          fmt_trap;
    logic          accept;
    logic          pop;

    load_formatter #(.DW(DW)) u_fmt (
        .mem_out     (mem_out),
        .alu_out     (alu_out),
        .mem_load    (mem_load),
        .size        (size),
        .load_signed (load_signed),
        .data        (fmt_data),
        .trap        (fmt_trap)
    );

    // A trapping entry never writes the register file.
    always_comb begin
        new_e       = '0;
        new_e.valid = 1'b1;
        new_e.data  = fmt_data;
        new_e.rd    = rd;
        new_e.le    = rf_le & ~fmt_trap;
        new_e.trap  = fmt_trap;
    end

    assign in_ready = ~s_q.valid;
    assign accept   = in_valid & in_ready;
    assign pop      = h_q.valid & out_ready;

    // Empty slots are written as all-zero so outputs read 0 when invalid.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            h_q <= '0;
            s_q <= '0;
        end else if (pop && s_q.valid) begin
            h_q <= s_q;
            s_q <= accept ? new_e : '0;
        end else if (pop) begin
            h_q <= accept ? new_e : '0;
        end else if (accept && h_q.valid) begin
            s_q <= new_e;
        end else if (accept) begin
            h_q <= new_e;
        end
    end

    assign out_valid       = h_q.valid;
    assign wb_data         = h_q.data;
    assign wb_rd           = h_q.rd;
    assign wb_le           = h_q.le;
    assign trap_misaligned = h_q.trap;

    assign fwd_valid = h_q.valid & h_q.le;
    assign fwd_rd    = h_q.rd;
    assign fwd_data  = h_q.data;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int W = 39;  // {data[31:0], rd[4:0], le, trap}

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] alu_out, mem_out;
    logic        mem_load, load_signed, rf_le;
    logic [1:0]  size;
    logic [4:0]  rd;
    logic        out_valid, out_ready;
    logic [31:0] wb_data, fwd_data;
    logic [4:0]  wb_rd, fwd_rd;
    logic        wb_le, trap_misaligned, fwd_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .mem_out(mem_out), .mem_load(mem_load),
        .size(size), .load_signed(load_signed), .rd(rd), .rf_le(rf_le),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_le(wb_le),
        .trap_misaligned(trap_misaligned),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Expected packed head {data, rd, le, trap} for one instruction.
    function automatic logic [W-1:0] model(input logic [31:0] a, input logic [31:0] m,
                                           input logic ld, input logic [1:0] sz,
                                           input logic sg, input logic [4:0] r,
                                           input logic le);
        logic [31:0] d;
        logic        t;
        d = a;
        t = 1'b0;
        if (ld) begin
            if (sz == 2'd0) begin
                d = m % 256;
                if (sg && d >= 128) d = d - 32'd256;
            end else if (sz == 2'd1) begin
                d = m % 65536;
                if (sg && d >= 32768) d = d - 32'd65536;
                t = (a % 2) != 0;
            end else if (sz == 2'd2) begin
                d = m;
                t = (a % 4) != 0;
            end else begin
                d = 0;
                t = 1'b1;
            end
        end
        return {d, r, le && !t, t};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] head();
        return {wb_data, wb_rd, wb_le, trap_misaligned};
    endfunction

    // ---------------- driver ----------------
    task automatic set_in(input logic [31:0] a, input logic [31:0] m, input logic ld,
                          input logic [1:0] sz, input logic sg, input logic [4:0] r,
                          input logic le);
        in_valid = 1'b1; alu_out = a; mem_out = m; mem_load = ld;
        size = sz; load_signed = sg; rd = r; rf_le = le;
    endtask

    // Offer one instruction for one edge, then sample at the next negedge.
    task automatic send(input logic [31:0] a, input logic [31:0] m, input logic ld,
                        input logic [1:0] sz, input logic sg, input logic [4:0] r,
                        input logic le);
        @(negedge clk);
        set_in(a, m, ld, sz, sg, r, le);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [W-1:0] ea, eb, ec, e;
    logic         acc, pp, fl;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_out = '0; mem_out = '0; mem_load = 1'b0; size = 2'd0;
        load_signed = 1'b0; rd = '0; rf_le = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_head", head(), '0);
        chk("rst_fwd_valid", fwd_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Signed byte load
        send(32'h0, 32'h000000F0, 1'b1, 2'd0, 1'b1, 5'd3, 1'b1);
        chk("ldsb_data", wb_data, 32'hFFFFFFF0);
        chk("ldsb_rd", wb_rd, 5'd3);
        chk("ldsb_le", wb_le, 1'b1);
        chk("ldsb_fwd_valid", fwd_valid, 1'b1);
        chk("ldsb_fwd", {fwd_data, fwd_rd}, {32'hFFFFFFF0, 5'd3});

        // ALU pass-through
        send(32'h12345678, 32'hDEADBEEF, 1'b0, 2'd2, 1'b0, 5'd7, 1'b1);
        chk("alu_data", wb_data, 32'h12345678);

        // Half loads, unsigned and signed
        send(32'h0, 32'h00008001, 1'b1, 2'd1, 1'b0, 5'd4, 1'b1);
        chk("lduh_data", wb_data, 32'h00008001);
        send(32'h0, 32'h00008001, 1'b1, 2'd1, 1'b1, 5'd4, 1'b1);
        chk("ldsh_data", wb_data, 32'hFFFF8001);

        // Misaligned word load, aligned half load
        send(32'h00000102, 32'h11223344, 1'b1, 2'd2, 1'b0, 5'd5, 1'b1);
        chk("misw_trap", trap_misaligned, 1'b1);
        chk("misw_le", wb_le, 1'b0);
        chk("misw_fwd_valid", fwd_valid, 1'b0);
        send(32'h00000004, 32'h00001234, 1'b1, 2'd1, 1'b0, 5'd6, 1'b1);
        chk("alh_trap", trap_misaligned, 1'b0);
        chk("alh_le", wb_le, 1'b1);

        // Reserved size encoding and misaligned half
        send(32'h0, 32'hFFFFFFFF, 1'b1, 2'd3, 1'b1, 5'd8, 1'b1);
        chk("sz11", head(), model(32'h0, 32'hFFFFFFFF, 1'b1, 2'd3, 1'b1, 5'd8, 1'b1));
        send(32'h3, 32'h0000ABCD, 1'b1, 2'd1, 1'b1, 5'd9, 1'b1);
        chk("mish", head(), model(32'h3, 32'h0000ABCD, 1'b1, 2'd1, 1'b1, 5'd9, 1'b1));

        // Skid: A, B, C back to back with writeback stalled
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        chk("skid_empty", out_valid, 1'b0);
        ea = model(32'hA0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd10, 1'b1);
        eb = model(32'hB0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd11, 1'b1);
        ec = model(32'hC0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd12, 1'b1);
        set_in(32'hA0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd10, 1'b1);
        @(negedge clk);
        chk("skid_a_in_ready", in_ready, 1'b1);
        set_in(32'hB0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd11, 1'b1);
        @(negedge clk);
        chk("skid_full_in_ready", in_ready, 1'b0);
        chk("skid_head_a", head(), ea);
        set_in(32'hC0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd12, 1'b1);
        @(negedge clk);
        chk("skid_hold_a", head(), ea);
        chk("skid_hold_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("skid_head_b", head(), eb);
        chk("skid_b_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("skid_head_c", head(), ec);
        @(negedge clk);
        chk("skid_drained", out_valid, 1'b0);

        // Flush with both entries full and an instruction offered
        out_ready = 1'b0;
        set_in(32'h1, 32'h0, 1'b0, 2'd0, 1'b0, 5'd1, 1'b1);
        @(negedge clk);
        set_in(32'h2, 32'h0, 1'b0, 2'd0, 1'b0, 5'd2, 1'b1);
        @(negedge clk);
        chk("flush_pre_full", in_ready, 1'b0);
        set_in(32'h3, 32'h0, 1'b0, 2'd0, 1'b0, 5'd3, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_le", {wb_le, fwd_valid}, 2'b00);
        chk("flush_head", head(), '0);

        // Reset mid-stall drops both entries
        set_in(32'h5, 32'h0, 1'b0, 2'd0, 1'b0, 5'd5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_full", in_ready, 1'b0);
        do_reset();
        chk("rst_stall_out_valid", out_valid, 1'b0);
        chk("rst_stall_in_ready", in_ready, 1'b1);

        // Random valid/ready/flush traffic against the in-order model
        exp_q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            chk("rnd_out_valid", out_valid, exp_q.size() > 0);
            chk("rnd_in_ready", in_ready, exp_q.size() < 2);
            if (exp_q.size() > 0) chk("rnd_head", head(), exp_q[0]);
            else chk("rnd_idle_head", head(), '0);
            set_in($urandom, $urandom, 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            fl        = ($urandom_range(0, 49) == 0);
            flush     = fl;
            acc = in_valid && exp_q.size() < 2;
            pp  = out_ready && exp_q.size() > 0;
            if (fl) begin
                exp_q.delete();
            end else begin
                if (pp) void'(exp_q.pop_front());
                if (acc) begin
                    e = model(alu_out, mem_out, mem_load, size, load_signed, rd, rf_le);
                    exp_q.push_back(e);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
